// File: rtl/monitor_disp_pkg.sv
// Shared constants and divider-ratio helpers for the monitor run/step controller
// and its multiplexed hex display.
package monitor_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; 6 and 9 carry tails, b and d are lowercase.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int step_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

  function automatic int scan_div(input int clk_hz, input int scan_hz, input int digits);
    int d;
    d = clk_hz / (scan_hz * digits);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit hex nibble to active-low 7-segment pattern.
module hex_to_7seg
  import monitor_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/monitor_disp_ctrl.sv
// Run/step CPU clock-enable generator with monitor-word snapshot and a
// time-multiplexed common-anode hex display.
module monitor_disp_ctrl
  import monitor_disp_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int STEP_HZ    = 1,
  parameter int SCAN_HZ    = 1000,
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mode_i,
  input  logic                  step_i,
  input  logic                  freeze_i,
  input  logic [DATA_W-1:0]     monitor_i,
  output logic                  cpu_en_o,
  output logic [DATA_W-1:0]     snap_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int STEP_DIV = step_div(CLK_HZ, STEP_HZ);
  localparam int SCAN_DIV = scan_div(CLK_HZ, SCAN_HZ, NUM_DIGITS);
  localparam int STEP_W   = cnt_width(STEP_DIV);
  localparam int SCAN_W   = cnt_width(SCAN_DIV);
  localparam int IDX_W    = cnt_width(NUM_DIGITS);
  localparam int NIBBLES  = DATA_W / 4;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic                  mode_q, mode_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic                  rise_q, rise_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  cap_q, cap_d;
  logic [DATA_W-1:0]     snap_q, snap_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic       mode_chg, scan_tick, hi_zero, in_range, blank;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  // Step pulse path: sync1/sync2 resynchronise the button, sync3 holds the
  // previous sample for rising-edge detection, rise_q is the pending edge.
  always_comb begin
    mode_chg = (mode_i != mode_q);
    mode_d   = mode_i;
    sync1_d  = step_i;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    rise_d   = sync2_q & ~sync3_q & ~mode_chg;

    if (mode_chg) begin
      step_cnt_d = '0;
      cpu_en_d   = 1'b0;
    end else if (mode_i) begin
      step_cnt_d = '0;
      cpu_en_d   = rise_q;
    end else begin
      step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_W'(1);
      cpu_en_d   = (step_cnt_q == STEP_LAST);
    end

    // Capture one cycle after the pulse so the CPU has already advanced.
    cap_d  = cpu_en_q;
    snap_d = (cap_q && !freeze_i) ? monitor_i : snap_q;
  end

  always_comb begin
    scan_tick  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    nib      = 4'h0;
    hi_zero  = 1'b1;
    in_range = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (i >= int'(idx_q) && snap_q[4*i +: 4] != 4'h0) hi_zero = 1'b0;
      if (i == int'(idx_q)) begin
        nib      = snap_q[4*i +: 4];
        in_range = 1'b1;
      end
    end

    blank = !in_range || (LZ_BLANK != 0 && idx_q != '0 && hi_zero);
    seg_d = blank ? SEG_BLANK : dec_seg;
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  hex_to_7seg u_hex (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // NOTE: state uses non-blocking assignments only, and reset is sampled on
  // the clock edge like any other input, so every flop clears synchronously.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q     <= mode_i;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rise_q     <= 1'b0;
      step_cnt_q <= '0;
      cpu_en_q   <= 1'b0;
      cap_q      <= 1'b0;
      snap_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      mode_q     <= mode_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      rise_q     <= rise_d;
      step_cnt_q <= step_cnt_d;
      cpu_en_q   <= cpu_en_d;
      cap_q      <= cap_d;
      snap_q     <= snap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign cpu_en_o = cpu_en_q;
  assign snap_o   = snap_q;
  assign seg_o    = seg_q;
  assign an_o     = an_q;

endmodule
